// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states, read-return owner tags
// and the starvation counter width.
package dmem_arbiter_pkg;

  localparam int ARB_WAIT_WIDTH = 3;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_CPU    = 2'd1,
    ARB_EXT    = 2'd2,
    ARB_EXT_LK = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } own_tag_e;

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating count of consecutive cycles a pending CPU request has been denied;
// limit_o tells the arbiter to break an external locked burst.
module arb_wait_counter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_o
);

  localparam logic [ARB_WAIT_WIDTH-1:0] LIMIT = ARB_WAIT_WIDTH'(MAX_WAIT);

  logic [ARB_WAIT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + ARB_WAIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter between the MCU datapath and the external
// debug/loader port: combinational grant, round-robin with burst lock, 1-cycle read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic                  ext_lock,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  arb_state_e            state_q, state_d;
  own_tag_e              tag_q, tag_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, ext_rdata_q;
  logic                  wait_limit;

  // Grants are gated by rst so nothing reaches the RAM while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    state_d = ARB_IDLE;
    if (rst) begin
      if (cpu_req && ext_req) begin
        unique case (state_q)
          ARB_CPU:    ext_gnt = 1'b1;
          ARB_EXT_LK: begin
            cpu_gnt = wait_limit;
            ext_gnt = !wait_limit;
          end
          default:    cpu_gnt = 1'b1;
        endcase
      end else begin
        cpu_gnt = cpu_req;
        ext_gnt = ext_req;
      end
    end
    if (cpu_gnt) begin
      state_d = ARB_CPU;
    end else if (ext_gnt) begin
      state_d = ext_lock ? ARB_EXT_LK : ARB_EXT;
    end
  end

  assign cpu_stall = rst && cpu_req && !cpu_gnt;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (cpu_stall),
    .clr_i   (cpu_gnt || !cpu_req),
    .limit_o (wait_limit)
  );

  always_comb begin
    ram_en    = cpu_gnt || ext_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    tag_d     = OWN_NONE;
    if (cpu_gnt) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      tag_d     = cpu_we ? OWN_NONE : OWN_CPU;
    end else if (ext_gnt) begin
      ram_we    = ext_we;
      ram_addr  = ext_addr;
      ram_wdata = ext_wdata;
      tag_d     = ext_we ? OWN_NONE : OWN_EXT;
    end
  end

  // Read return: RAM data passes straight through in the return cycle, then is held.
  assign cpu_rvalid = (tag_q == OWN_CPU);
  assign ext_rvalid = (tag_q == OWN_EXT);
  assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;
  assign ext_rdata  = ext_rvalid ? ram_rdata : ext_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      tag_q       <= OWN_NONE;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      cpu_rdata_q <= cpu_rdata;
      ext_rdata_q <= ext_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
  logic       cpu_gnt, cpu_rvalid, cpu_stall;
  logic [7:0] cpu_rdata;
  logic       ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
  logic [7:0] ext_addr = 8'h00, ext_wdata = 8'h00;
  logic       ext_gnt, ext_rvalid;
  logic [7:0] ext_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .MAX_WAIT   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_lock   (ext_lock),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Unwritten locations read as ~addr, except 0xAE which holds 0x5A.
  logic [7:0] mem [256];
  bit         wr  [256] = '{default: 1'b0};

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wr[ram_addr]  <= 1'b1;
      end else if (wr[ram_addr]) begin
        ram_rdata <= mem[ram_addr];
      end else begin
        ram_rdata <= (ram_addr == 8'hAE) ? 8'h5A : ~ram_addr;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01; cpu_wdata = 8'h00;
    ext_req = 1'b1; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = 8'h02; ext_wdata = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, cpu_stall, ram_en, ram_we} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000000",
               {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, cpu_stall, ram_en, ram_we});
    end
    checks++;
    if ({cpu_rdata, ext_rdata, ram_addr, ram_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 00000000", {cpu_rdata, ext_rdata, ram_addr, ram_wdata});
    end
    rst = 1'b1; #1;
    checks++;
    if ({cpu_gnt, ext_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_gnt got %b exp 10", {cpu_gnt, ext_gnt});
    end
    @(negedge clk); cpu_req = 1'b0; ext_req = 1'b0; #1;
    checks++;
    if ({cpu_rvalid, ext_rvalid, cpu_rdata} !== {2'b10, 8'hFE}) begin
      errors++;
      $display("FAIL reset_first_read got %b %b %h exp 1 0 fe", cpu_rvalid, ext_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'hAE; #1;
    checks++;
    if ({cpu_gnt, ext_gnt, ram_en, ram_we, ram_addr, cpu_stall} !== {4'b1010, 8'hAE, 1'b0}) begin
      errors++;
      $display("FAIL cpu_read_grant got %b %b %b %b %h %b exp 1 0 1 0 ae 0",
               cpu_gnt, ext_gnt, ram_en, ram_we, ram_addr, cpu_stall);
    end
    @(negedge clk); cpu_req = 1'b0; #1;
    checks++;
    if ({cpu_rvalid, ext_rvalid, cpu_rdata} !== {2'b10, 8'h5A}) begin
      errors++;
      $display("FAIL cpu_read_data got %b %b %h exp 1 0 5a", cpu_rvalid, ext_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ctl [5];
    logic [7:0] exp_crd [5];
    logic [7:0] exp_erd [5];
    logic [7:0] ca, ea;
    exp_ctl = '{4'b1000, 4'b0110, 4'b1001, 4'b0110, 4'b0001};
    exp_crd = '{8'h5A, 8'hDF, 8'hDF, 8'hDE, 8'hDE};
    exp_erd = '{8'h00, 8'h00, 8'hCF, 8'hCF, 8'hCE};
    ca = 8'h20;
    ea = 8'h30;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cpu_req = (k < 4); ext_req = (k < 4);
      cpu_we = 1'b0; ext_we = 1'b0; ext_lock = 1'b0;
      cpu_addr = ca; ext_addr = ea; #1;
      checks++;
      if ({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid} !== exp_ctl[k]) begin
        errors++;
        $display("FAIL rr_ctl[%0d] got %b exp %b", k,
                 {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid}, exp_ctl[k]);
      end
      checks++;
      if (cpu_rdata !== exp_crd[k]) begin
        errors++;
        $display("FAIL rr_cpu_rdata[%0d] got %h exp %h", k, cpu_rdata, exp_crd[k]);
      end
      checks++;
      if (ext_rdata !== exp_erd[k]) begin
        errors++;
        $display("FAIL rr_ext_rdata[%0d] got %h exp %h", k, ext_rdata, exp_erd[k]);
      end
      if (exp_ctl[k][3]) ca = ca + 8'h01;
      if (exp_ctl[k][2]) ea = ea + 8'h01;
    end
  endtask

  task automatic test_store();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'hAE; cpu_wdata = 8'h33;
    ext_req = 1'b0; #1;
    checks++;
    if ({ram_en, ram_we, cpu_gnt, ext_gnt, cpu_stall} !== 5'b11100) begin
      errors++;
      $display("FAIL store_ctl got %b exp 11100", {ram_en, ram_we, cpu_gnt, ext_gnt, cpu_stall});
    end
    checks++;
    if ({ram_addr, ram_wdata} !== 16'hAE33) begin
      errors++;
      $display("FAIL store_bus got %h exp ae33", {ram_addr, ram_wdata});
    end
  endtask

  // Starts right after the store, so the arbiter's last grant was the CPU.
  task automatic test_locked_burst();
    int idx = 0;
    int ext_cnt = 0;
    int stall_cnt = 0;
    logic exp_c, exp_e;
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      cpu_req = (j < 5); cpu_we = 1'b0; cpu_addr = 8'h50;
      ext_req = (idx < 10); ext_we = 1'b1; ext_lock = 1'b1;
      ext_addr = 8'(8'h10 + idx); ext_wdata = 8'(8'hA0 + idx); #1;
      exp_c = (j == 4);
      exp_e = (j != 4);
      if (j == 0) begin
        checks++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b00) begin
          errors++;
          $display("FAIL store_no_rvalid got %b exp 00", {cpu_rvalid, ext_rvalid});
        end
      end
      checks++;
      if ({cpu_gnt, ext_gnt, cpu_stall} !== {exp_c, exp_e, (j < 4)}) begin
        errors++;
        $display("FAIL burst_gnt[%0d] got %b exp %b", j,
                 {cpu_gnt, ext_gnt, cpu_stall}, {exp_c, exp_e, (j < 4)});
      end
      if (exp_e) begin
        checks++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 8'(8'h10 + idx), 8'(8'hA0 + idx)}) begin
          errors++;
          $display("FAIL burst_bus[%0d] got %b %h %h exp 1 %h %h", j, ram_we, ram_addr,
                   ram_wdata, 8'(8'h10 + idx), 8'(8'hA0 + idx));
        end
      end
      if (j == 5) begin
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hAF}) begin
          errors++;
          $display("FAIL burst_cpu_read got %b %h exp 1 af", cpu_rvalid, cpu_rdata);
        end
      end
      if (ext_gnt) ext_cnt++;
      if (cpu_stall) stall_cnt++;
      if (exp_e) idx++;
    end
    checks++;
    if (ext_cnt != 10) begin
      errors++;
      $display("FAIL burst_ext_count got %0d exp 10", ext_cnt);
    end
    checks++;
    if (stall_cnt != 4) begin
      errors++;
      $display("FAIL burst_stall_count got %0d exp 4", stall_cnt);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    cpu_req = 1'b0; ext_req = 1'b1; ext_we = 1'b0; ext_lock = 1'b0; ext_addr = 8'h60; #1;
    checks++;
    if (ext_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_grant got %b exp 1", ext_gnt);
    end
    rst = 1'b0; #1;
    checks++;
    if ({ext_gnt, ram_en} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_gate got %b exp 00", {ext_gnt, ram_en});
    end
    @(negedge clk); ext_req = 1'b0; #1;
    checks++;
    if (ext_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rvalid_in_reset got %b exp 0", ext_rvalid);
    end
    rst = 1'b1; #1;
    checks++;
    if (dut.state_q !== ARB_IDLE) begin
      errors++;
      $display("FAIL midrst_state got %0d exp %0d", dut.state_q, ARB_IDLE);
    end
    @(negedge clk); #1;
    checks++;
    if ({cpu_rvalid, ext_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_rvalid_after got %b exp 00", {cpu_rvalid, ext_rvalid});
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_round_robin();
    test_store();
    test_locked_burst();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port data RAM between two requesters: the MCU datapath (LOAD/ADD/SUB/STORE operand traffic) and the external debug/loader port.
- Issues at most one RAM access per cycle, using round-robin arbitration, an external burst lock and a CPU starvation bound.
- Drives `cpu_stall` to the MCU so the control unit holds `pc_count`/`opcode_update` while the CPU's RAM access is pending.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 8, RAM address width
- MAX_WAIT, 4, max consecutive cycles a pending CPU request may be denied (1..7)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (all state cleared while 0)
- cpu_req / cpu_we  in  1 / 1  CPU access request / write enable
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_WIDTH  CPU read data
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- ext_req / ext_we / ext_lock  in  1 / 1 / 1  external request / write enable / hold ownership for burst
- ext_addr  in  ADDR_WIDTH; ext_wdata  in  DATA_WIDTH
- ext_gnt / ext_rvalid  out  1 / 1
- ext_rdata  out  DATA_WIDTH
- ram_en / ram_we  out  1 / 1  RAM strobe / write
- ram_addr  out  ADDR_WIDTH; ram_wdata  out  DATA_WIDTH
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after read strobe

## Operation
- Handshake:
  - A requester holds req, we, addr and wdata stable until it samples gnt=1 at a rising edge.
  - The gnt is combinational, and the access happens in that same cycle.
  - `ram_*` mirror the granted requester; `ram_en` = cpu_gnt | ext_gnt, and the two grants are never both high.
- FSM states: IDLE, CPU (last grant CPU), EXT (last grant ext, unlocked), EXT_LK (last grant ext with ext_lock=1).
- Arbitration per cycle:
  - Only one req → grant it.
  - Both req in IDLE/EXT → CPU. Both in CPU → EXT.
  - Both in EXT_LK → EXT, unless wait_cnt == MAX_WAIT, in which case → CPU.
- Next state:
  - no grant → IDLE
  - cpu_gnt → CPU
  - ext_gnt & ext_lock → EXT_LK
  - ext_gnt & ~ext_lock → EXT
- wait_cnt (3 bit):
  - Increments when cpu_req & ~cpu_gnt.
  - Clears on cpu_gnt or ~cpu_req.
  - Saturates at MAX_WAIT and never wraps.
- Reads:
  - Owner tag is registered at grant when we=0.
  - Next cycle, the tagged requester's rvalid=1 and its rdata=ram_rdata.
  - The other requester's rdata holds its last value.
  - Writes produce no rvalid.
- Lock release: ext_lock=0 or ext_req=0 ends the burst immediately.

## Timing
- Reset values: all grants, rvalids, ram_en, ram_we and cpu_stall = 0; rdata, ram_addr and ram_wdata = 0; state IDLE; wait_cnt 0; read tag none.
- Grant latency: 0 cycles when uncontended. Read data latency: 1 cycle after grant. Write completes at the granting edge.
- Worst-case CPU wait: MAX_WAIT cycles.
- Back-to-back reads by alternating owners are allowed. rvalid pipelines one per cycle.
- Simultaneous req on the exit from reset: CPU wins, because the reset state is IDLE.
- rst asserted mid-read: the pending rvalid is dropped. No rvalid appears after reset release.
- Requests with req=0 are ignored whatever the other inputs are.

## Structure
- defs.v constants:
  - state encodings ARB_IDLE/ARB_CPU/ARB_EXT/ARB_EXT_LK (2 bit)
  - owner tag codes OWN_NONE/OWN_CPU/OWN_EXT
  - ARB_WAIT_WIDTH = 3
- One sub-module, `arb_wait_counter`: saturating starvation counter with inc/clr/limit outputs.
- Everything else lives in dmem_arbiter: FSM, grant logic and read-return pipeline.

## Test plan
- Reset: hold rst=0 with both req=1 → all outputs 0. Release rst → first cycle cpu_gnt=1, ext_gnt=0.
- CPU read: cpu_req=1, addr=0xAE, RAM returns 0x5A → cpu_gnt same cycle; next cycle cpu_rvalid=1, cpu_rdata=0x5A, ext_rvalid=0.
- Round-robin: both requesters issue continuous reads with ext_lock=0 → grants alternate CPU, EXT, CPU, EXT…, and each rvalid goes to the correct requester.
- Locked burst with MAX_WAIT=4: ext_lock=1 burst of 10 writes to 0x10..0x19, cpu_req=1 throughout → 4 ext grants, then 1 CPU grant, then ext resumes. cpu_stall is high for exactly the 4 denied cycles.
- STORE path: cpu_we=1, addr=0xAE, wdata=0x33 → ram_en=1, ram_we=1, ram_addr=0xAE, ram_wdata=0x33 in the grant cycle; no rvalid afterwards.
- Reset mid-read: ext read granted, rst=0 before the next edge → ext_rvalid stays 0 and the state is IDLE after release.
